rd_circ_buf_wrap_align: RTL and testbench
=========================================

// Module: rd_circ_buf_wrap_align
// PURPOSE
//  Read-side engine for a power-of-2 circular buffer in DRAM. Accepts {offset,size} read requests and
//  splits any request that crosses the buffer end into two memory reads. Merges the two response streams
//  into one contiguous, left-justified beat stream with its own last/padbytes. Sits between a consumer
//  (e.g. MAC TX path) and a rd_mem_noc_module-style memory reader. Internal FSM; no external shift controls.
// PARAMETERS
//  DATA_W      512  beat width in bits, multiple of 8; DATA_BYTES=DATA_W/8, PAD_W=$clog2(DATA_BYTES)
//  BUF_BYTES_W 12   log2 of circular buffer size in bytes; BUF_BYTES=1<<BUF_BYTES_W, multiple of DATA_BYTES
//  ADDR_W      64   memory byte-address width
//  SIZE_W      16   request size width in bytes
// PORTS
//  clk                       in   1            clock
//  rst                       in   1            synchronous, active-high reset
//  buf_base_addr             in   ADDR_W       buffer base (DATA_BYTES aligned), sampled on request accept
//  src_rd_req_val            in   1            read request valid
//  src_rd_req_offset         in   BUF_BYTES_W  start offset inside buffer
//  src_rd_req_size           in   SIZE_W       bytes to read, legal range 1..BUF_BYTES
//  rd_src_req_rdy            out  1            request ready
//  rd_mem_req_val            out  1            memory read request valid
//  rd_mem_req_addr           out  ADDR_W       memory byte address
//  rd_mem_req_size           out  SIZE_W       memory read size in bytes
//  mem_rd_req_rdy            in   1            memory request ready
//  mem_rd_resp_val           in   1            response beat valid (left-justified, byte 0 in MSBs)
//  mem_rd_resp_data          in   DATA_W       response data
//  mem_rd_resp_last          in   1            last beat of one memory read
//  mem_rd_resp_padbytes      in   PAD_W        invalid LSB bytes of the last beat
//  rd_mem_resp_rdy           out  1            response ready
//  rd_dst_data_val           out  1            output beat valid
//  rd_dst_data               out  DATA_W       output beat, pad bytes forced to zero
//  rd_dst_data_last          out  1            last beat of the request
//  rd_dst_data_padbytes      out  PAD_W        invalid LSB bytes on the last beat, else 0
//  dst_rd_data_rdy           in   1            output ready
// BEHAVIOUR
//  Reset: FSM=IDLE, carry register and carry_bytes=0, all valids 0, rd_mem_resp_rdy=0, rd_src_req_rdy=1.
//  States: IDLE -> REQ0 -> [REQ1] -> STREAM -> [FLUSH] -> IDLE.
//   IDLE:   rd_src_req_rdy=1. On accept, latch base, offset, size; wrap = offset+size > BUF_BYTES
//           (computed BUF_BYTES_W+1 bits wide). seg0_size = wrap ? BUF_BYTES-offset : size; seg1_size =
//           size-seg0_size. size==0: accepted, no memory request, no output, stay IDLE.
//   REQ0:   val=1, addr=base+offset, size=seg0_size; on handshake -> REQ1 if wrap else STREAM.
//   REQ1:   val=1, addr=base, size=seg1_size; on handshake -> STREAM. Values are held while stalled.
//   STREAM: responses arrive in request order; seg flag selects seg0/seg1 and toggles on seg0 last beat.
//  Merge (zero-latency, combinational from carry reg and response):
//   carry_bytes==0: beat passes through; rd_mem_resp_rdy=dst_rd_data_rdy; val=mem_rd_resp_val.
//   seg0 last beat with wrap and padbytes P!=0: beat is absorbed into carry (carry_bytes=DATA_BYTES-P),
//     rd_mem_resp_rdy=1, no output that cycle.
//   carry_bytes=C>0: out = {carry[top C bytes], resp[top DATA_BYTES-C bytes]}; new carry = remaining resp
//     bytes; output and response handshake together (rd_mem_resp_rdy=dst_rd_data_rdy).
//   Final response beat (seg1 last, or seg0 last when !wrap): if valid carry+resp bytes > DATA_BYTES ->
//     emit full beat, -> FLUSH; else emit with last=1 -> IDLE on output handshake.
//   FLUSH:  rd_mem_resp_rdy=0; emit carry alone, last=1; -> IDLE on output handshake.
//  Output padbytes on last = (DATA_BYTES - size%DATA_BYTES)%DATA_BYTES; bytes below mask are zero.
//  Output val never depends on dst_rd_data_rdy; data/last/padbytes stable while val&&!rdy.
//  rd_src_req_rdy=0 from accept until final output handshake; next request accepted the cycle after.
//  Reset mid-operation returns to IDLE immediately; in-flight memory responses are not drained (memory
//  reader is reset with this block). Illegal size>BUF_BYTES: behaviour undefined, assertion in sim.
// TESTING (DATA_W=64, BUF_BYTES_W=6, base=0x1000)
//  no wrap: offset 8 size 16 -> one mem req (0x1008,16); 2 beats passed through, last pad 0.
//  aligned wrap: offset 56 size 16 -> reqs (0x1038,8),(0x1000,8); 2 output beats unchanged, last pad 0.
//  misaligned wrap: offset 61 size 10 -> reqs (0x103D,3),(0x1000,7); resp A0-A2 pad5, B0-B6 pad1 -> out
//   {A0-A2,B0-B4} then FLUSH {B5,B6,0x00 x6} last=1 pad6.
//  backpressure: repeat previous with random dst_rd_data_rdy/mem_rd_req_rdy -> identical byte stream,
//   no beat lost or duplicated, outputs stable while stalled.
//  reset asserted in STREAM -> next cycle all valids 0, rd_src_req_rdy=1, fresh request behaves as test 1.
//  back-to-back requests held valid + size 0 request -> each accepted cycle after prior last handshake;
//   size 0 produces no memory request and no output.

Source files
------------

// File: rtl/rd_circ_buf_wrap_align.sv
// Read engine for a power-of-2 circular buffer: splits wrapping reads into two
// memory requests and merges both response streams into one left-justified beat stream.
module rd_circ_buf_wrap_align #(
  parameter int unsigned DATA_W      = 512,
  parameter int unsigned BUF_BYTES_W = 12,
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned SIZE_W      = 16,
  localparam int unsigned DATA_BYTES = DATA_W / 8,
  localparam int unsigned PAD_W      = $clog2(DATA_BYTES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      buf_base_addr,
  input  logic                   src_rd_req_val,
  input  logic [BUF_BYTES_W-1:0] src_rd_req_offset,
  input  logic [SIZE_W-1:0]      src_rd_req_size,
  output logic                   rd_src_req_rdy,
  output logic                   rd_mem_req_val,
  output logic [ADDR_W-1:0]      rd_mem_req_addr,
  output logic [SIZE_W-1:0]      rd_mem_req_size,
  input  logic                   mem_rd_req_rdy,
  input  logic                   mem_rd_resp_val,
  input  logic [DATA_W-1:0]      mem_rd_resp_data,
  input  logic                   mem_rd_resp_last,
  input  logic [PAD_W-1:0]       mem_rd_resp_padbytes,
  output logic                   rd_mem_resp_rdy,
  output logic                   rd_dst_data_val,
  output logic [DATA_W-1:0]      rd_dst_data,
  output logic                   rd_dst_data_last,
  output logic [PAD_W-1:0]       rd_dst_data_padbytes,
  input  logic                   dst_rd_data_rdy
);

  localparam int unsigned BUF_BYTES = 1 << BUF_BYTES_W;
  localparam int unsigned CNT_W     = PAD_W + 1;
  localparam int unsigned OFS_W     = BUF_BYTES_W + 1;

  typedef enum logic [2:0] {ST_IDLE, ST_REQ0, ST_REQ1, ST_STREAM, ST_FLUSH} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      base_q, base_d;
  logic [BUF_BYTES_W-1:0] offset_q, offset_d;
  logic [SIZE_W-1:0]      seg0_size_q, seg0_size_d;
  logic [SIZE_W-1:0]      seg1_size_q, seg1_size_d;
  logic                   wrap_q, wrap_d;
  logic                   seg_q, seg_d;
  logic [PAD_W-1:0]       pad_last_q, pad_last_d;
  logic [DATA_W-1:0]      carry_q, carry_d;
  logic [CNT_W-1:0]       carry_bytes_q, carry_bytes_d;

  logic [OFS_W-1:0]  wrap_sum;
  logic              req_wrap;
  logic [CNT_W-1:0]  resp_bytes;
  logic [CNT_W-1:0]  total;
  logic              final_beat;
  logic              absorb;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] spill;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W-1:0] last_mask;

  // Mask keeping the top n bytes of a beat (n may equal DATA_BYTES).
  function automatic logic [DATA_W-1:0] top_mask(input logic [CNT_W-1:0] n);
    return ~({DATA_W{1'b1}} >> {n, 3'b000});
  endfunction

  // Next-state, request generation and zero-latency merge of carry with the response beat.
  always_comb begin
    state_d         = state_q;
    base_d          = base_q;
    offset_d        = offset_q;
    seg0_size_d     = seg0_size_q;
    seg1_size_d     = seg1_size_q;
    wrap_d          = wrap_q;
    seg_d           = seg_q;
    pad_last_d      = pad_last_q;
    carry_d         = carry_q;
    carry_bytes_d   = carry_bytes_q;
    rd_src_req_rdy  = 1'b0;
    rd_mem_req_val  = 1'b0;
    rd_mem_req_addr = '0;
    rd_mem_req_size = '0;
    rd_mem_resp_rdy = 1'b0;
    rd_dst_data_val = 1'b0;
    rd_dst_data_last     = 1'b0;
    rd_dst_data_padbytes = '0;
    out_data        = '0;

    wrap_sum   = OFS_W'(src_rd_req_offset) + OFS_W'(src_rd_req_size);
    req_wrap   = wrap_sum > OFS_W'(BUF_BYTES);
    resp_bytes = mem_rd_resp_last ? CNT_W'(DATA_BYTES) - CNT_W'(mem_rd_resp_padbytes)
                                  : CNT_W'(DATA_BYTES);
    total      = carry_bytes_q + resp_bytes;
    final_beat = mem_rd_resp_last && (seg_q || !wrap_q);
    absorb     = (carry_bytes_q == '0) && !seg_q && wrap_q && mem_rd_resp_last &&
                 (mem_rd_resp_padbytes != '0);
    merged     = carry_q | (mem_rd_resp_data >> {carry_bytes_q, 3'b000});
    spill      = mem_rd_resp_data << {CNT_W'(DATA_BYTES) - carry_bytes_q, 3'b000};
    last_mask  = top_mask(CNT_W'(DATA_BYTES) - CNT_W'(pad_last_q));

    unique case (state_q)
      ST_IDLE: begin
        rd_src_req_rdy = 1'b1;
        if (src_rd_req_val) begin
          base_d        = buf_base_addr;
          offset_d      = src_rd_req_offset;
          wrap_d        = req_wrap;
          seg0_size_d   = req_wrap ? SIZE_W'(BUF_BYTES) - SIZE_W'(src_rd_req_offset)
                                   : src_rd_req_size;
          seg1_size_d   = src_rd_req_size - seg0_size_d;
          // Low PAD_W bits of (DATA_BYTES - size) give the tail padding of the whole request.
          pad_last_d    = PAD_W'(CNT_W'(DATA_BYTES) - CNT_W'(src_rd_req_size));
          seg_d         = 1'b0;
          carry_d       = '0;
          carry_bytes_d = '0;
          if (src_rd_req_size != '0) state_d = ST_REQ0;
        end
      end
      ST_REQ0: begin
        rd_mem_req_val  = 1'b1;
        rd_mem_req_addr = base_q + ADDR_W'(offset_q);
        rd_mem_req_size = seg0_size_q;
        if (mem_rd_req_rdy) state_d = wrap_q ? ST_REQ1 : ST_STREAM;
      end
      ST_REQ1: begin
        rd_mem_req_val  = 1'b1;
        rd_mem_req_addr = base_q;
        rd_mem_req_size = seg1_size_q;
        if (mem_rd_req_rdy) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (absorb) begin
          // Partial tail of the first segment becomes the carry; nothing emitted.
          rd_mem_resp_rdy = 1'b1;
          if (mem_rd_resp_val) begin
            carry_d       = mem_rd_resp_data & top_mask(resp_bytes);
            carry_bytes_d = resp_bytes;
            seg_d         = 1'b1;
          end
        end else begin
          rd_mem_resp_rdy = dst_rd_data_rdy;
          rd_dst_data_val = mem_rd_resp_val;
          out_data        = merged;
          if (final_beat && (total > CNT_W'(DATA_BYTES))) begin
            if (mem_rd_resp_val && dst_rd_data_rdy) begin
              carry_d       = spill & top_mask(total - CNT_W'(DATA_BYTES));
              carry_bytes_d = total - CNT_W'(DATA_BYTES);
              state_d       = ST_FLUSH;
            end
          end else if (final_beat) begin
            rd_dst_data_last     = 1'b1;
            rd_dst_data_padbytes = pad_last_q;
            if (mem_rd_resp_val && dst_rd_data_rdy) begin
              carry_d       = '0;
              carry_bytes_d = '0;
              state_d       = ST_IDLE;
            end
          end else if (mem_rd_resp_val && dst_rd_data_rdy) begin
            carry_d = spill & top_mask(carry_bytes_q);
            if (mem_rd_resp_last) seg_d = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        rd_dst_data_val      = 1'b1;
        rd_dst_data_last     = 1'b1;
        rd_dst_data_padbytes = pad_last_q;
        out_data             = carry_q;
        if (dst_rd_data_rdy) begin
          carry_d       = '0;
          carry_bytes_d = '0;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rd_dst_data = rd_dst_data_last ? (out_data & last_mask) : out_data;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      base_q        <= '0;
      offset_q      <= '0;
      seg0_size_q   <= '0;
      seg1_size_q   <= '0;
      wrap_q        <= 1'b0;
      seg_q         <= 1'b0;
      pad_last_q    <= '0;
      carry_q       <= '0;
      carry_bytes_q <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      offset_q      <= offset_d;
      seg0_size_q   <= seg0_size_d;
      seg1_size_q   <= seg1_size_d;
      wrap_q        <= wrap_d;
      seg_q         <= seg_d;
      pad_last_q    <= pad_last_d;
      carry_q       <= carry_d;
      carry_bytes_q <= carry_bytes_d;
    end
  end

  // Requests larger than the buffer are a caller bug.
  always_ff @(posedge clk) begin
    if (!rst && src_rd_req_val && rd_src_req_rdy) begin
      assert (32'(src_rd_req_size) <= BUF_BYTES);
    end
  end

endmodule

// File: tb/tb_rd_circ_buf_wrap_align.sv
// Randomized bench for rd_circ_buf_wrap_align with a byte-level reference model.
module tb_rd_circ_buf_wrap_align;

  localparam int unsigned DW = 64, DB = 8, PW = 3, BW = 6, AW = 64, SW = 16, BUFB = 64;
  localparam logic [AW-1:0] BASE = 64'h1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] buf_base_addr = BASE;
  logic          src_rd_req_val = 1'b0;
  logic [BW-1:0] src_rd_req_offset = '0;
  logic [SW-1:0] src_rd_req_size = '0;
  logic          rd_src_req_rdy;
  logic          rd_mem_req_val;
  logic [AW-1:0] rd_mem_req_addr;
  logic [SW-1:0] rd_mem_req_size;
  logic          mem_rd_req_rdy = 1'b0;
  logic          mem_rd_resp_val = 1'b0;
  logic [DW-1:0] mem_rd_resp_data = '0;
  logic          mem_rd_resp_last = 1'b0;
  logic [PW-1:0] mem_rd_resp_padbytes = '0;
  logic          rd_mem_resp_rdy;
  logic          rd_dst_data_val;
  logic [DW-1:0] rd_dst_data;
  logic          rd_dst_data_last;
  logic [PW-1:0] rd_dst_data_padbytes;
  logic          dst_rd_data_rdy = 1'b0;

  always #5 clk = ~clk;

  rd_circ_buf_wrap_align #(.DATA_W(DW), .BUF_BYTES_W(BW), .ADDR_W(AW), .SIZE_W(SW)) dut (
    .clk(clk), .rst(rst), .buf_base_addr(buf_base_addr),
    .src_rd_req_val(src_rd_req_val), .src_rd_req_offset(src_rd_req_offset),
    .src_rd_req_size(src_rd_req_size), .rd_src_req_rdy(rd_src_req_rdy),
    .rd_mem_req_val(rd_mem_req_val), .rd_mem_req_addr(rd_mem_req_addr),
    .rd_mem_req_size(rd_mem_req_size), .mem_rd_req_rdy(mem_rd_req_rdy),
    .mem_rd_resp_val(mem_rd_resp_val), .mem_rd_resp_data(mem_rd_resp_data),
    .mem_rd_resp_last(mem_rd_resp_last), .mem_rd_resp_padbytes(mem_rd_resp_padbytes),
    .rd_mem_resp_rdy(rd_mem_resp_rdy), .rd_dst_data_val(rd_dst_data_val),
    .rd_dst_data(rd_dst_data), .rd_dst_data_last(rd_dst_data_last),
    .rd_dst_data_padbytes(rd_dst_data_padbytes), .dst_rd_data_rdy(dst_rd_data_rdy)
  );

  typedef struct packed { logic [DW-1:0] data; logic last; logic [PW-1:0] pad; } beat_t;
  typedef struct packed { logic [AW-1:0] addr; logic [SW-1:0] size; } mreq_t;
  typedef struct packed { logic [BW-1:0] off; logic [SW-1:0] size; } sreq_t;

  logic [7:0] mem [BUFB];
  beat_t resp_q[$];
  beat_t exp_out_q[$];
  mreq_t exp_req_q[$];
  sreq_t src_q[$];

  int    checks = 0, passed = 0;
  int    cyc = 0, done_cyc = 0, present_cyc = 0;
  int    dst_mode = 0, mreq_mode = 0;
  bit    resp_gap = 1'b0, busy = 1'b0, drop_src = 1'b0, resp_taken = 1'b0, prev_stall = 1'b0;
  beat_t prev_out = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic sreq_t mk(input int off, input int size);
    sreq_t s;
    s.off  = BW'(off);
    s.size = SW'(size);
    return s;
  endfunction

  function automatic logic pick(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) return 1'($urandom_range(0, 1));
    return 1'b0;
  endfunction

  function automatic void fill_mem();
    for (int i = 0; i < BUFB; i++) mem[i] = 8'($urandom);
  endfunction

  // Expected memory requests and output beats from the request rules, byte by byte.
  function automatic void model_accept(input sreq_t s);
    int o, n, s0, nb, k;
    mreq_t r;
    beat_t e;
    o = int'(s.off);
    n = int'(s.size);
    if (n == 0) return;
    if (o + n > BUFB) begin
      s0 = BUFB - o;
      r.addr = BASE + AW'(o); r.size = SW'(s0); exp_req_q.push_back(r);
      r.addr = BASE;          r.size = SW'(n - s0); exp_req_q.push_back(r);
    end else begin
      r.addr = BASE + AW'(o); r.size = SW'(n); exp_req_q.push_back(r);
    end
    nb = (n + DB - 1) / DB;
    for (int b = 0; b < nb; b++) begin
      e = '0;
      for (int i = 0; i < DB; i++) begin
        k = b * DB + i;
        if (k < n) e.data[DW-1-8*i -: 8] = mem[(o + k) % BUFB];
      end
      e.last = (b == nb - 1);
      e.pad  = e.last ? PW'((DB - n % DB) % DB) : '0;
      exp_out_q.push_back(e);
    end
  endfunction

  // Memory reader model: response beats for one accepted memory request, junk in pad bytes.
  function automatic void mem_serve(input mreq_t r);
    int o, n, nb, k;
    beat_t e;
    o  = int'(r.addr[BW-1:0]);
    n  = int'(r.size);
    nb = (n + DB - 1) / DB;
    for (int b = 0; b < nb; b++) begin
      e.data = {$urandom, $urandom};
      for (int i = 0; i < DB; i++) begin
        k = b * DB + i;
        if (k < n) e.data[DW-1-8*i -: 8] = mem[(o + k) % BUFB];
      end
      e.last = (b == nb - 1);
      e.pad  = e.last ? PW'((DB - n % DB) % DB) : '0;
      resp_q.push_back(e);
    end
  endfunction

  // One cycle: drive at the falling edge, then observe what the next rising edge will commit.
  task automatic tick();
    beat_t e;
    mreq_t r;
    sreq_t s;
    @(negedge clk);
    cyc++;
    if (drop_src) begin src_rd_req_val = 1'b0; drop_src = 1'b0; end
    if (!src_rd_req_val && src_q.size() > 0) begin
      src_rd_req_val    = 1'b1;
      src_rd_req_offset = src_q[0].off;
      src_rd_req_size   = src_q[0].size;
      present_cyc       = cyc;
    end
    if (resp_taken) begin mem_rd_resp_val = 1'b0; resp_taken = 1'b0; end
    if (!mem_rd_resp_val && resp_q.size() > 0 && (!resp_gap || $urandom_range(0, 2) != 0)) begin
      mem_rd_resp_val      = 1'b1;
      mem_rd_resp_data     = resp_q[0].data;
      mem_rd_resp_last     = resp_q[0].last;
      mem_rd_resp_padbytes = resp_q[0].pad;
    end
    dst_rd_data_rdy = pick(dst_mode);
    mem_rd_req_rdy  = pick(mreq_mode);
    #1;
    chk("src_rdy", 128'(rd_src_req_rdy), 128'(!busy));
    if (prev_stall)
      chk("out_hold", 128'({rd_dst_data_val, rd_dst_data, rd_dst_data_last, rd_dst_data_padbytes}),
          128'({1'b1, prev_out}));
    prev_stall = rd_dst_data_val && !dst_rd_data_rdy;
    prev_out   = {rd_dst_data, rd_dst_data_last, rd_dst_data_padbytes};
    if (rd_mem_req_val && mem_rd_req_rdy) begin
      r = {rd_mem_req_addr, rd_mem_req_size};
      if (exp_req_q.size() == 0) chk("mem_req_unexpected", 128'(rd_mem_req_val), 128'(1'b0));
      else chk("mem_req", 128'(r), 128'(exp_req_q.pop_front()));
      mem_serve(r);
    end
    if (mem_rd_resp_val && rd_mem_resp_rdy) begin
      e = resp_q.pop_front();
      resp_taken = 1'b1;
    end
    if (rd_dst_data_val && dst_rd_data_rdy) begin
      if (exp_out_q.size() == 0) chk("out_unexpected", 128'(rd_dst_data_val), 128'(1'b0));
      else begin
        e = exp_out_q.pop_front();
        chk("out_beat", 128'({rd_dst_data, rd_dst_data_last, rd_dst_data_padbytes}), 128'(e));
        if (e.last) begin busy = 1'b0; done_cyc = cyc; end
      end
    end
    if (src_rd_req_val && rd_src_req_rdy && src_q.size() > 0) begin
      s = src_q.pop_front();
      if (present_cyc <= done_cyc + 1) chk("accept_cycle", 128'(cyc), 128'(done_cyc + 1));
      model_accept(s);
      if (s.size != '0) busy = 1'b1;
      else done_cyc = cyc;
      drop_src = 1'b1;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || src_q.size() > 0 || (src_rd_req_val && !drop_src) || exp_req_q.size() > 0 ||
            resp_q.size() > 0 || exp_out_q.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    chk("idle_within_budget", 128'(n < budget), 128'(1'b1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    cyc++;
    rst = 1'b1;
    src_rd_req_val = 1'b0; mem_rd_resp_val = 1'b0; dst_rd_data_rdy = 1'b0; mem_rd_req_rdy = 1'b0;
    src_q.delete(); exp_req_q.delete(); exp_out_q.delete(); resp_q.delete();
    busy = 1'b0; drop_src = 1'b0; resp_taken = 1'b0; prev_stall = 1'b0;
    @(negedge clk);
    cyc++;
    rst = 1'b0;
    #1;
    chk("rst_mem_req_val", 128'(rd_mem_req_val), 128'(1'b0));
    chk("rst_out_val", 128'(rd_dst_data_val), 128'(1'b0));
    chk("rst_resp_rdy", 128'(rd_mem_resp_rdy), 128'(1'b0));
    chk("rst_src_rdy", 128'(rd_src_req_rdy), 128'(1'b1));
    done_cyc = cyc;
  endtask

  task automatic modes(input int d, input int m, input bit g);
    dst_mode = d; mreq_mode = m; resp_gap = g;
  endtask

  initial begin
    int n;
    do_reset();

    // No wrap: one memory request, two pass-through beats.
    fill_mem(); modes(0, 0, 1'b0);
    src_q.push_back(mk(8, 16));
    wait_idle(200);

    // Aligned wrap: two requests, beats unchanged.
    fill_mem();
    src_q.push_back(mk(56, 16));
    wait_idle(200);

    // Misaligned wrap with recognisable bytes.
    fill_mem();
    for (int i = 0; i < 3; i++) mem[61 + i] = 8'(8'hA0 + i);
    for (int i = 0; i < 7; i++) mem[i] = 8'(8'hB0 + i);
    src_q.push_back(mk(61, 10));
    wait_idle(200);

    // Same request under random backpressure on every handshake.
    modes(1, 1, 1'b1);
    for (int t = 0; t < 6; t++) begin
      src_q.push_back(mk(61, 10));
      wait_idle(400);
    end

    // Reset while streaming with the consumer stalled.
    fill_mem(); modes(2, 0, 1'b0);
    src_q.push_back(mk(8, 16));
    n = 0;
    while ((src_q.size() > 0 || exp_req_q.size() > 0) && n < 50) begin tick(); n++; end
    repeat (3) tick();
    chk("stalled_out_val", 128'(rd_dst_data_val), 128'(1'b1));
    do_reset();
    modes(0, 0, 1'b0);
    src_q.push_back(mk(8, 16));
    wait_idle(200);

    // Back-to-back held-valid requests including size 0.
    fill_mem();
    src_q.push_back(mk(8, 16));
    src_q.push_back(mk(5, 0));
    src_q.push_back(mk(61, 10));
    src_q.push_back(mk(0, 0));
    src_q.push_back(mk(20, 64));
    src_q.push_back(mk(0, 64));
    wait_idle(800);

    // Random batches of back-to-back requests under random flow control.
    for (int b = 0; b < 12; b++) begin
      fill_mem();
      modes(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 4; i++)
        src_q.push_back(mk(int'($urandom_range(0, BUFB - 1)),
                           ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, BUFB))));
      wait_idle(2000);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
